fir_mac_sched: RTL and testbench

- Sequencer for a time-multiplexed FIR filter built around one signed multiply-accumulate lane.
- Holds the coefficient bank and the sample delay line, and accepts one input sample per handshake.
- Issues TAPS multiply-accumulate steps, one per cycle, then scales and saturates the result.
- Presents the result on a valid/ready output port.
- Sits between the streaming sample source and downstream DSP stages in the accelerator datapath.

---
 rtl/fir_pkg.sv | 56 +++++
 rtl/fir_mac_step.sv | 56 +++++
 rtl/fir_mac_sched.sv | 176 +++++++++++++++++
 tb/tb_fir_mac_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fir_pkg : shared FSM state, MAC width rule and output saturation    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam int DEF_DATA_WIDTH = 13;
  localparam int DEF_TAPS       = 8;
  localparam int DEF_FRAC_BITS  = 11;

  localparam int SAT_IN_W  = 64;
  localparam int SAT_OUT_W = 32;

  function automatic int fir_acc_width(input int data_width, input int taps);
    return 2 * data_width + $clog2(taps);
  endfunction

  localparam int DEF_ACC_WIDTH = fir_acc_width(DEF_DATA_WIDTH, DEF_TAPS);

  typedef struct packed {
    logic                 sat;
    logic [SAT_OUT_W-1:0] val;
  } sat_res_t;

  // Floor shift (arithmetic, no rounding) then clip to the signed output range.
  function automatic sat_res_t sat_trunc(input logic signed [SAT_IN_W-1:0] acc,
                                         input int frac_bits,
                                         input int data_width);
    logic signed [SAT_IN_W-1:0] sh;
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    sat_res_t res;
    sh = acc >>> frac_bits;
    hi = (64'sd1 <<< (data_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_width - 1));
    res.sat = 1'b0;
    res.val = sh[SAT_OUT_W-1:0];
    if (sh > hi) begin
      res.sat = 1'b1;
      res.val = hi[SAT_OUT_W-1:0];
    end else if (sh < lo) begin
      res.sat = 1'b1;
      res.val = lo[SAT_OUT_W-1:0];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mac_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fir_mac_step : registered signed accumulator, acc += a*b            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fir_mac_step
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0]  acc_next_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]        a_ext;
  logic signed [PW-1:0]        b_ext;
  logic signed [PW-1:0]        prod;
  logic        [ACC_WIDTH-1:0] acc_q;
  logic        [ACC_WIDTH-1:0] acc_d;
  logic        [ACC_WIDTH-1:0] acc_sum;

  // Operands widened first so the truncated product keeps the full signed result.
  assign a_ext   = {{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i};
  assign b_ext   = {{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i};
  assign prod    = a_ext * b_ext;
  assign acc_sum = acc_q + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

  assign acc_next_o = acc_sum;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_sum;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_mac_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fir_mac_sched : FIR sequencer driving one MAC lane, TAPS steps/out  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fir_mac_sched
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAPS       = DEF_TAPS,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                     CLK,
  input  logic                     RST_n,
  input  logic                     clear,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [DATA_WIDTH-1:0]    coef_data,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     sat,
  output logic                     busy
);

  localparam int             KW        = $clog2(TAPS);
  localparam int             ACC_WIDTH = fir_acc_width(DATA_WIDTH, TAPS);
  localparam logic [KW-1:0]  K_LAST    = KW'(TAPS - 1);

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [DATA_WIDTH-1:0]  x_q [TAPS];
  logic [DATA_WIDTH-1:0]  h_q [TAPS];
  logic [DATA_WIDTH-1:0]  dout_q;
  logic                   sat_q;
  logic                   dout_valid_q;

  logic                   addr_ok;
  logic                   accept;
  logic                   coef_wr;
  logic                   mac_clr;
  logic                   mac_en;
  logic                   out_load;
  logic                   out_done;
  logic [ACC_WIDTH-1:0]   acc_next;
  sat_res_t               sat_res;
  logic                   unused_sat_bits;

  if ((1 << KW) != TAPS) begin : g_addr_chk
    assign addr_ok = (32'(coef_addr) < TAPS);
  end else begin : g_addr_full
    assign addr_ok = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    accept   = 1'b0;
    coef_wr  = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    out_load = 1'b0;
    out_done = 1'b0;
    if (clear) begin
      state_d = IDLE;
      k_d     = '0;
      mac_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          coef_wr = coef_we & addr_ok;
          // A coefficient write takes the cycle; the sample waits for the next one.
          if (din_valid && !coef_we) begin
            accept  = 1'b1;
            mac_clr = 1'b1;
            k_d     = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          mac_en = 1'b1;
          if (k_q == K_LAST) begin
            k_d      = '0;
            out_load = 1'b1;
            state_d  = OUT;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        OUT: begin
          if (dout_ready) begin
            out_done = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
    end else if (accept) begin
      for (int i = TAPS - 1; i > 0; i--) x_q[i] <= x_q[i-1];
      x_q[0] <= din;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < TAPS; i++) h_q[i] <= '0;
    end else if (coef_wr) begin
      h_q[coef_addr] <= coef_data;
    end
  end

  fir_mac_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .clr_i      (mac_clr),
    .en_i       (mac_en),
    .a_i        (x_q[k_q]),
    .b_i        (h_q[k_q]),
    .acc_next_o (acc_next)
  );

  // The final product is folded in combinationally so OUT follows the last step.
  assign sat_res = sat_trunc({{(SAT_IN_W-ACC_WIDTH){acc_next[ACC_WIDTH-1]}}, acc_next},
                             FRAC_BITS, DATA_WIDTH);
  assign unused_sat_bits = ^sat_res.val[SAT_OUT_W-1:DATA_WIDTH];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      dout_q       <= '0;
      sat_q        <= 1'b0;
      dout_valid_q <= 1'b0;
    end else if (clear) begin
      dout_q       <= '0;
      sat_q        <= 1'b0;
      dout_valid_q <= 1'b0;
    end else if (out_load) begin
      dout_q       <= sat_res.val[DATA_WIDTH-1:0];
      sat_q        <= sat_res.sat;
      dout_valid_q <= 1'b1;
    end else if (out_done) begin
      dout_valid_q <= 1'b0;
    end
  end

  assign din_ready  = RST_n & (state_q == IDLE) & ~coef_we & ~clear;
  assign dout       = dout_q;
  assign sat        = sat_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fir_mac_sched : directed bench with a convolution reference      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_fir_mac_sched;

  localparam int DW   = 13;
  localparam int TAPS = 8;
  localparam int FRAC = 11;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          clear = 1'b0;
  logic          coef_we = 1'b0;
  logic [2:0]    coef_addr = '0;
  logic [DW-1:0] coef_data = '0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          sat;
  logic          busy;

  always #5 CLK = ~CLK;

  fir_mac_sched #(.DATA_WIDTH(DW), .TAPS(TAPS), .FRAC_BITS(FRAC)) dut (
    .CLK(CLK), .RST_n(RST_n), .clear(clear), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .sat(sat), .busy(busy)
  );

  typedef struct { int y; int s; int due; } exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   edges = 0;
  int   hm [TAPS];
  int   xm [TAPS];
  exp_t exp_q [$];
  int   last_dout = 0;
  int   last_sat = 0;
  bit   seen_cur = 1'b0;

  always @(posedge CLK) edges <= edges + 1;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int sdout();
    int v;
    v = $signed(dout);
    return v;
  endfunction

  // Reference: direct convolution of the last TAPS samples, floor shift, clip.
  function automatic void model_accept(input int v);
    longint a;
    int     s;
    for (int i = TAPS - 1; i > 0; i--) xm[i] = xm[i-1];
    xm[0] = v;
    a = 0;
    for (int i = 0; i < TAPS; i++) a += longint'(xm[i]) * longint'(hm[i]);
    a = a >>> FRAC;
    s = 0;
    if (a > MAXV) begin a = MAXV; s = 1; end
    else if (a < MINV) begin a = MINV; s = 1; end
    exp_q.push_back('{y: int'(a), s: s, due: edges + TAPS + 1});
  endfunction

  function automatic void model_flush(input bit coefs_too);
    for (int i = 0; i < TAPS; i++) begin
      xm[i] = 0;
      if (coefs_too) hm[i] = 0;
    end
    exp_q.delete();
    seen_cur = 1'b0;
  endfunction

  always @(negedge CLK) begin
    if (RST_n) begin
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", int'(dout_valid), 0);
        end else begin
          chk("dout", sdout(), exp_q[0].y);
          chk("sat", int'(sat), exp_q[0].s);
          if (!seen_cur) begin
            chk("latency", edges, exp_q[0].due);
            seen_cur = 1'b1;
          end
          if (dout_ready) begin
            last_dout = sdout();
            last_sat  = int'(sat);
            void'(exp_q.pop_front());
            seen_cur = 1'b0;
          end
        end
      end else if (exp_q.size() != 0 && edges > exp_q[0].due) begin
        chk("missing_valid", int'(dout_valid), 1);
        void'(exp_q.pop_front());
        seen_cur = 1'b0;
      end
    end
  end

  task automatic wr(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = 3'(a);
    coef_data = DW'(d);
    @(posedge CLK); #1;
    coef_we = 1'b0;
    hm[a]   = d;
  endtask

  task automatic send(input int v, output int waited);
    bit got;
    got       = 1'b0;
    waited    = 0;
    din       = DW'(v);
    din_valid = 1'b1;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge CLK);
      if (din_ready) got = 1'b1;
      else waited++;
    end
    if (got) model_accept(v);
    else chk("accept_timeout", int'(din_ready), 1);
    @(posedge CLK); #1;
    din_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge CLK);
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge CLK); #1;
  endtask

  task automatic wait_valid();
    bit got;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge CLK);
      if (dout_valid) got = 1'b1;
    end
    if (!got) chk("valid_timeout", int'(dout_valid), 1);
  endtask

  task automatic sd(input int v);
    int w;
    send(v, w);
    drain();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge CLK); #1;
    clear = 1'b0;
    model_flush(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual running, required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int hold_d;
    int hold_s;
    model_flush(1'b1);

    din_valid = 1'b1;
    #12;
    chk("rst_dout", sdout(), 0);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_din_ready", int'(din_ready), 0);
    din_valid = 1'b0;
    @(negedge CLK); RST_n = 1'b1;
    @(posedge CLK); #1;

    // Identity filter
    wr(0, 2048);
    sd(100);   chk("id_100", last_dout, 100);  chk("id_100_sat", last_sat, 0);
    sd(-37);   chk("id_m37", last_dout, -37);
    sd(4095);  chk("id_4095", last_dout, 4095); chk("id_4095_sat", last_sat, 0);

    // Impulse response
    pulse_clear();
    for (int i = 0; i < TAPS; i++) wr(i, 100 * (i + 1));
    sd(2048);  chk("imp_0", last_dout, 100);
    for (int i = 1; i <= TAPS; i++) begin
      sd(0);
      chk("imp_n", last_dout, (i < TAPS) ? 100 * (i + 1) : 0);
    end

    // Saturation both directions
    for (int i = 0; i < TAPS; i++) wr(i, 2047);
    for (int i = 0; i < TAPS; i++) sd(4095);
    chk("sat_pos", last_dout, 4095);  chk("sat_pos_flag", last_sat, 1);
    for (int i = 0; i < TAPS; i++) sd(-4096);
    chk("sat_neg", last_dout, -4096); chk("sat_neg_flag", last_sat, 1);

    // Backpressure in OUT
    dout_ready = 1'b0;
    send(1000, w);
    wait_valid();
    hold_d = sdout();
    hold_s = int'(sat);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_dout", sdout(), hold_d);
      chk("bp_sat", int'(sat), hold_s);
      chk("bp_valid", int'(dout_valid), 1);
      chk("bp_din_ready", int'(din_ready), 0);
      chk("bp_busy", int'(busy), 1);
    end
    @(posedge CLK); #1;
    dout_ready = 1'b1;
    drain();

    // Coefficient writes during RUN are ignored
    wr(0, 2048);
    for (int i = 1; i < TAPS; i++) wr(i, 0);
    send(500, w);
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = DW'(5);
    @(posedge CLK); #1;
    coef_addr = 3'd1; coef_data = DW'(7);
    @(posedge CLK); #1;
    coef_we = 1'b0;
    drain();
    chk("run_we_500", last_dout, 500);
    sd(321);
    chk("rerun_identity", last_dout, 321);

    // Write and sample in the same IDLE cycle: write wins
    din = DW'(77); din_valid = 1'b1;
    coef_we = 1'b1; coef_addr = 3'd1; coef_data = DW'(2048);
    @(negedge CLK);
    chk("conflict_ready", int'(din_ready), 0);
    @(posedge CLK); #1;
    coef_we = 1'b0;
    hm[1] = 2048;
    send(77, w);
    chk("conflict_wait", w, 0);
    drain();
    chk("conflict_out", last_dout, 398);

    // clear mid-RUN
    for (int i = 0; i < TAPS; i++) wr(i, 100 * (i + 1));
    send(1234, w);
    repeat (3) @(posedge CLK);
    #1;
    pulse_clear();
    @(negedge CLK);
    chk("clear_busy", int'(busy), 0);
    chk("clear_valid", int'(dout_valid), 0);
    repeat (12) @(posedge CLK);
    #1;
    sd(2048);  chk("clear_imp0", last_dout, 100);
    sd(0);     chk("clear_imp1", last_dout, 200);

    // Reset mid-OUT
    dout_ready = 1'b0;
    send(2048, w);
    wait_valid();
    @(posedge CLK); #2;
    RST_n = 1'b0;
    model_flush(1'b1);
    #1;
    chk("arst_dout", sdout(), 0);
    chk("arst_valid", int'(dout_valid), 0);
    chk("arst_sat", int'(sat), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_din_ready", int'(din_ready), 0);
    @(negedge CLK);
    RST_n = 1'b1;
    dout_ready = 1'b1;
    @(posedge CLK); #1;
    last_dout = -1;
    sd(2048);
    chk("arst_coef_zero", last_dout, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
